// File: rtl/bitserial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package bitserial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bitserial_adder_fa_cell.sv
// One-bit full adder assembled from two half-adder cells plus an OR of their carries.
module ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1;
    logic c1;
    logic c2;

    ha u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
    ha u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

    assign co = c1 | c2;
endmodule

// File: rtl/bitserial_adder.sv
// Sequential adder computing a+b+cin one bit per clock, LSB first, with valid/ready handshakes.
module bitserial_adder
    import bitserial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] shA;
    logic [WIDTH-1:0] shB;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             faSum;
    logic             faCarry;
    logic [WIDTH:0]   sumShift;

    fa_cell u_fa (
        .a  (shA[0]),
        .b  (shB[0]),
        .ci (carry),
        .s  (faSum),
        .co (faCarry)
    );

    // New bit enters at the MSB; written this way so WIDTH=1 needs no special case.
    assign sumShift = {faSum, sum};

    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            shA   <= '0;
            shB   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        shA   <= a;
                        shB   <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum   <= sumShift[WIDTH:1];
                    shA   <= shA >> 1;
                    shB   <= shB >> 1;
                    carry <= faCarry;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        cout  <= faCarry;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bitserial_adder.md
Name: bitserial_adder

Overview:
- Multi-bit adder that computes a+b+cin one bit per clock, LSB first, using one full-adder cell and a carry register.
- Sits upstream of result consumers: valid/ready input accepts operands, valid/ready output presents sum and carry-out.
- It is the area-minimal sequential counterpart to the team's combinational half-adder and full-adder cells, for wide operands where one cell per bit is too costly.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is WIDTH >= 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a, b, cin are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  sum and cout are valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  (a+b+cin) mod 2^WIDTH.
- cout  out  1  bit WIDTH of a+b+cin.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on rst. All outputs are registered or decoded from registered state.
- Reset values:
  - state = IDLE.
  - out_valid = 0, sum = 0, cout = 0, busy = 0.
  - Internal shift registers, carry register and bit counter = 0.
  - in_ready = 0 while rst is high, 1 in the first cycle after rst falls.
- in_ready = (state==IDLE) && !rst.
- out_valid = (state==DONE).
- busy = (state!=IDLE).
- FSM states:
  - IDLE: on in_valid && in_ready, load shA<=a, shB<=b, carry<=cin, cnt<=0, then go to RUN. Otherwise hold.
  - RUN: each cycle, the full-adder cell computes {c,s} = shA[0]+shB[0]+carry.
    - sum shifts right with s entering the MSB.
    - shA and shB shift right; carry<=c; cnt<=cnt+1.
    - When cnt==WIDTH-1: cout<=c and go to DONE.
  - DONE: hold sum and cout stable. On out_ready go to IDLE; otherwise stay.
- Latency:
  - With operands accepted at edge k, out_valid rises after edge k+WIDTH.
  - Minimum throughput is one operation per WIDTH+2 cycles.
- Input sampling:
  - a, b and cin are sampled only at the accept edge.
  - Input changes during RUN or DONE are ignored.
  - in_valid while not IDLE is ignored; no input buffering.
- Output hold:
  - In IDLE, sum and cout keep the last result but out_valid is 0.
  - sum bits are not valid to consumers while in RUN.
- Counter width: $clog2(WIDTH+1) bits. With WIDTH=1, RUN lasts exactly one cycle.
- Arithmetic:
  - No signed interpretation.
  - Overflow is reported only through cout; no saturation.
- Simultaneous events: out_ready in DONE returns to IDLE. A new operand is accepted no earlier than the following cycle, since there is no same-cycle pass-through.
- Reset mid-operation: rst during RUN or DONE abandons the operation. The next cycle is IDLE with out_valid=0, sum=0, cout=0. No partial result is emitted.
- out_ready outside DONE has no effect.

Decomposition:
- Shared package/include bitserial_pkg:
  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Encoding 2'd3 is illegal and recovers to ST_IDLE.
- Sub-module fa_cell: one-bit full adder built from two instances of the team's ha half-adder cell, plus an OR of their carries. Purely combinational, instantiated once.

Test Plan:
1. Basic add and latency: reset, then WIDTH=8, a=8'h0F, b=8'h01, cin=0 accepted at edge k -> out_valid rises after edge k+8, sum=8'h10, cout=0, busy high for 9 cycles with out_ready held 1.
2. Overflow: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
3. Backpressure: complete a=8'h12, b=8'h34 with out_ready=0 for 5 cycles and in_valid pulsing -> out_valid held, sum=8'h46 stable, in_ready=0, no new operand taken. Raise out_ready -> IDLE next cycle, in_ready=1.
4. Input isolation: accept a=8'hA5, b=8'h5A, cin=0, then drive a=8'h00, b=8'h00 during RUN -> sum=8'hFF, cout=0.
5. Reset mid-RUN: assert rst after 3 RUN cycles -> next cycle out_valid=0, sum=0, cout=0, in_ready=1. Then a=8'h80, b=8'h80 -> sum=8'h00, cout=1.
6. WIDTH=1 instance: a=1, b=1, cin=1 -> out_valid one cycle after accept, sum=1, cout=1. Also a=0, b=0, cin=0 -> sum=0, cout=0.
